// File: rtl/seq_alu_unit_if.sv
// Operand/result bundle for seq_alu_unit.
// master drives the request, slave returns the result.
interface seq_alu_unit_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] C;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, op, A, B,
    input  C, busy, done, err
  );

  modport slave (
    input  start, op, A, B,
    output C, busy, done, err
  );
endinterface

// File: rtl/seq_alu_unit.sv
// Clocked two-operand ALU with start/done handshake.
// Single-cycle ADD/SUB/AND/OR/XOR, WIDTH-cycle shift-add MUL.
module seq_alu_unit #(
  parameter int WIDTH      = 4,
  parameter bit MUL_ENABLE = 1'b1
) (
  input logic           clk,
  input logic           rst,
  seq_alu_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t state_q, state_d;

  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    c_q, c_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [W2-1:0]    alu;
  logic [W2-1:0]    step;
  logic             op_add, op_sub, op_and;
  logic             op_or, op_xor, op_mul;

  assign op_add = bus.op == 3'd0;
  assign op_sub = bus.op == 3'd1;
  assign op_and = bus.op == 3'd2;
  assign op_or  = bus.op == 3'd3;
  assign op_xor = bus.op == 3'd4;
  assign op_mul = (bus.op == 3'd5) && MUL_ENABLE;

  // Bit WIDTH of the extended difference is the borrow.
  assign sum  = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff = {1'b0, bus.A} - {1'b0, bus.B};

  always_comb begin
    alu = '0;
    unique case (1'b1)
      op_add:  alu = {{(WIDTH-1){1'b0}}, sum};
      op_sub:  alu = {{(WIDTH-1){1'b0}}, diff};
      op_and:  alu = {{WIDTH{1'b0}}, bus.A & bus.B};
      op_or:   alu = {{WIDTH{1'b0}}, bus.A | bus.B};
      op_xor:  alu = {{WIDTH{1'b0}}, bus.A ^ bus.B};
      default: alu = '0;
    endcase
  end

  assign step = mplier_q[0]
    ? acc_q + (mcand_q << cnt_q)
    : acc_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (op_mul) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.A};
            mplier_d = bus.B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else if (bus.op < 3'd5) begin
            c_d    = alu;
            done_d = 1'b1;
          end else begin
            c_d    = '0;
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Last partial product folds straight into C.
        if (cnt_q == CW'(WIDTH - 1)) begin
          c_d     = step;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      c_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.C    = c_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.busy = (state_q == MUL);

endmodule

// File: tb/tb_seq_alu_unit.sv
// Self-checking bench for seq_alu_unit.
// Three builds: W4, W4 without MUL, W8.
module tb_seq_alu_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seq_alu_unit_if #(.WIDTH(4)) if4 ();
  seq_alu_unit_if #(.WIDTH(4)) ifn ();
  seq_alu_unit_if #(.WIDTH(8)) if8 ();

  // The no-MUL build sees exactly the W4 stimulus.
  assign ifn.start = if4.start;
  assign ifn.op    = if4.op;
  assign ifn.A     = if4.A;
  assign ifn.B     = if4.B;

  seq_alu_unit #(.WIDTH(4), .MUL_ENABLE(1'b1)) u4 (
    .clk (clk), .rst (rst), .bus (if4.slave)
  );
  seq_alu_unit #(.WIDTH(4), .MUL_ENABLE(1'b0)) un (
    .clk (clk), .rst (rst), .bus (ifn.slave)
  );
  seq_alu_unit #(.WIDTH(8), .MUL_ENABLE(1'b1)) u8 (
    .clk (clk), .rst (rst), .bus (if8.slave)
  );

  function automatic longint model(
    input int w, input int op, input bit mul_en,
    input longint a, input longint b
  );
    longint m;
    m = (longint'(1) << w) - 1;
    case (op)
      0: return a + b;
      1: return ((a - b) & m) | ((a < b) ? (longint'(1) << w) : 0);
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return mul_en ? a * b : 0;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do4(input int op, input int a, input int b);
    int lat, bc;
    longint nc;
    logic nd, ne;
    string t;
    t = $sformatf("w4 op%0d %0h,%0h", op, a, b);
    if4.start = 1'b1;
    if4.op = 3'(op);
    if4.A = 4'(a);
    if4.B = 4'(b);
    @(posedge clk); #1;
    if4.start = 1'b0;
    lat = 1;
    bc = 0;
    nc = longint'(ifn.C);
    nd = ifn.done;
    ne = ifn.err;
    while (!if4.done && lat < 20) begin
      bc += int'(if4.busy);
      @(posedge clk); #1;
      lat++;
    end
    chk({t, " C"}, longint'(if4.C), model(4, op, 1'b1, a, b) & 'hFF);
    chk({t, " err"}, longint'(if4.err), longint'(op > 5));
    chk({t, " lat"}, lat, (op == 5) ? 5 : 1);
    chk({t, " busy"}, bc, (op == 5) ? 4 : 0);
    chk({t, " nomul done"}, longint'(nd), 1);
    chk({t, " nomul err"}, longint'(ne), longint'(op >= 5));
    chk({t, " nomul C"}, nc, model(4, op, 1'b0, a, b) & 'hFF);
  endtask

  task automatic do8(input int op, input int a, input int b);
    int lat, bc;
    string t;
    t = $sformatf("w8 op%0d %0h,%0h", op, a, b);
    if8.start = 1'b1;
    if8.op = 3'(op);
    if8.A = 8'(a);
    if8.B = 8'(b);
    @(posedge clk); #1;
    if8.start = 1'b0;
    lat = 1;
    bc = 0;
    while (!if8.done && lat < 30) begin
      bc += int'(if8.busy);
      @(posedge clk); #1;
      lat++;
    end
    chk({t, " C"}, longint'(if8.C), model(8, op, 1'b1, a, b) & 'hFFFF);
    chk({t, " err"}, longint'(if8.err), longint'(op > 5));
    chk({t, " lat"}, lat, (op == 5) ? 9 : 1);
    chk({t, " busy"}, bc, (op == 5) ? 8 : 0);
  endtask

  initial begin
    int dn;
    if4.start = 1'b0; if4.op = '0; if4.A = '0; if4.B = '0;
    if8.start = 1'b0; if8.op = '0; if8.A = '0; if8.B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst C", longint'(if4.C), 0);
    chk("rst busy", longint'(if4.busy), 0);
    chk("rst done", longint'(if4.done), 0);
    chk("rst err", longint'(if4.err), 0);
    chk("rst w8 C", longint'(if8.C), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do4(0, 'hF, 'h1);
    chk("add F+1", longint'(if4.C), 'h10);
    do4(1, 3, 5);
    chk("sub 3-5", longint'(if4.C), 'h1E);
    do4(1, 5, 3);
    chk("sub b2b done", longint'(if4.done), 1);
    chk("sub 5-3", longint'(if4.C), 'h02);
    @(posedge clk); #1;
    chk("done pulse", longint'(if4.done), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("C hold", longint'(if4.C), 'h02);

    // MUL with an ADD request held during busy.
    if4.start = 1'b1; if4.op = 3'd5; if4.A = 4'hF; if4.B = 4'hF;
    @(posedge clk); #1;
    if4.op = 3'd0; if4.A = 4'h1; if4.B = 4'h1;
    dn = 0;
    repeat (3) begin
      chk("mul busy", longint'(if4.busy), 1);
      @(posedge clk); #1;
      dn += int'(if4.done);
    end
    if4.start = 1'b0;
    chk("busy ign done", dn, 0);
    chk("mul busy last", longint'(if4.busy), 1);
    @(posedge clk); #1;
    chk("mul FF done", longint'(if4.done), 1);
    chk("mul FF C", longint'(if4.C), 'hE1);
    chk("mul FF busy", longint'(if4.busy), 0);
    @(posedge clk); #1;
    chk("mul no extra", longint'(if4.done), 0);
    chk("mul C hold", longint'(if4.C), 'hE1);

    // Reset in the middle of a multiply.
    if4.start = 1'b1; if4.op = 3'd5; if4.A = 4'h7; if4.B = 4'h6;
    @(posedge clk); #1;
    if4.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst busy", longint'(if4.busy), 0);
    chk("mrst C", longint'(if4.C), 0);
    dn = 0;
    repeat (8) begin
      dn += int'(if4.done);
      @(posedge clk); #1;
    end
    chk("mrst no done", dn, 0);
    do4(0, 1, 1);
    chk("post rst add", longint'(if4.C), 2);

    do4(7, 'hC, 'hA);
    chk("illegal err", longint'(if4.err), 1);
    do4(2, 'hC, 'hA);
    chk("and C&A", longint'(if4.C), 'h08);
    chk("and err", longint'(if4.err), 0);
    do4(6, 3, 3);

    for (int op = 0; op < 6; op++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          do4(op, a, b);

    repeat (20) do4(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)));

    do8(0, 'hFF, 'hFF);
    chk("w8 FF+FF", longint'(if8.C), 'h01FE);
    do8(5, 'hFF, 'hFF);
    chk("w8 FFxFF", longint'(if8.C), 'hFE01);
    repeat (30) do8(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
